// File: rtl/sprite_plotter_pkg.sv
// Shared sprite/screen geometry, coordinate widths and plotter FSM states.
// Pure declarations; no latency or flow control of its own.
// Imported by the plotter top and its pixel scanner.
package sprite_plotter_pkg;

    localparam int SPRITE_W      = 40;
    localparam int SPRITE_H      = 40;
    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int COLOUR_W      = 3;
    localparam int X_W           = 8;
    localparam int Y_W           = 7;
    localparam int SPRITE_ADDR_W = 11;
    localparam int CNT_W         = 6;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_pixel_scanner.sv
// Raster-order col/row counters plus linear sprite ROM address.
// Latency: address/col/row registered, advance one pixel per enabled cycle.
// Backpressure: none; holds on the last pixel until cleared.
module sprite_pixel_scanner
    import sprite_plotter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    output logic [CNT_W-1:0]         col,
    output logic [CNT_W-1:0]         row,
    output logic [SPRITE_ADDR_W-1:0] addr,
    output logic                     last
);

    logic col_wrap;

    assign col_wrap = (col == CNT_W'(SPRITE_W - 1));
    assign last     = col_wrap && (row == CNT_W'(SPRITE_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (en && !last) begin
            addr <= addr + 1'b1;
            if (col_wrap) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_plotter.sv
// Draws one 40x40 sprite from ROM into the VGA framebuffer at a latched origin.
// Latency: first plot 2 cycles after accepted start, done 1602 cycles after it.
// Backpressure: none; start is ignored unless IDLE. Optional: SPRITE_PLOTTER_TRANSPARENCY_EN.
module sprite_plotter
    import sprite_plotter_pkg::*;
`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
#(
    parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = '0
)
`endif
(
    input  logic                     clk,
    input  logic                     spritePlotterReset,
    input  logic                     start,
    input  logic [X_W-1:0]           originX,
    input  logic [Y_W-1:0]           originY,
    output logic [SPRITE_ADDR_W-1:0] spriteAddress,
    input  logic [COLOUR_W-1:0]      romColour,
    output logic [X_W-1:0]           vgaX,
    output logic [Y_W-1:0]           vgaY,
    output logic [COLOUR_W-1:0]      vgaColour,
    output logic                     plot,
    output logic                     busy,
    output logic                     done
);

    state_t           state_q, state_d;
    logic             accept;
    logic             drawing;
    logic [CNT_W-1:0] col, row;
    logic             last;
    logic [X_W-1:0]   org_x;
    logic [Y_W-1:0]   org_y;
    logic [X_W:0]     sum_x;
    logic [Y_W:0]     sum_y;
    logic             on_screen;
    logic             pix_plot;

    always_ff @(posedge clk or posedge spritePlotterReset) begin
        if (spritePlotterReset) state_q <= IDLE;
        else                    state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAW;
                    accept  = 1'b1;
                end
            end
            DRAW:    if (last) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign drawing = (state_q == DRAW);
    assign busy    = (state_q == DRAW) || (state_q == FLUSH);
    assign done    = (state_q == DONE);

    // Clearing in DONE parks the address back at 0 for the following IDLE.
    sprite_pixel_scanner u_scanner (
        .clk  (clk),
        .rst  (spritePlotterReset),
        .clr  (accept || (state_q == DONE)),
        .en   (drawing),
        .col  (col),
        .row  (row),
        .addr (spriteAddress),
        .last (last)
    );

    // Widened sums so off-screen pixels are clipped rather than wrapped.
    assign sum_x     = {1'b0, org_x} + (X_W+1)'(col);
    assign sum_y     = {1'b0, org_y} + (Y_W+1)'(row);
    assign on_screen = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));

    // Pixel stage: one cycle behind the address, aligned with ROM data.
    always_ff @(posedge clk or posedge spritePlotterReset) begin
        if (spritePlotterReset) begin
            org_x    <= '0;
            org_y    <= '0;
            pix_plot <= 1'b0;
            vgaX     <= '0;
            vgaY     <= '0;
        end else begin
            if (accept) begin
                org_x <= originX;
                org_y <= originY;
            end
            pix_plot <= drawing && on_screen;
            if (drawing && on_screen) begin
                vgaX <= sum_x[X_W-1:0];
                vgaY <= sum_y[Y_W-1:0];
            end
        end
    end

    assign vgaColour = romColour;

`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
    assign plot = pix_plot && (romColour != TRANSPARENT_COLOUR);
`else
    assign plot = pix_plot;
`endif

endmodule

// File: tb/tb_sprite_plotter.sv
// Randomized bench for sprite_plotter against a per-cycle expectation model.
module tb_sprite_plotter;

    localparam int SW = 40;
    localparam int SH = 40;
    localparam int NCYC = 1603;
`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  originX;
    logic [6:0]  originY;
    logic [10:0] spriteAddress;
    logic [2:0]  romColour;
    logic [7:0]  vgaX;
    logic [6:0]  vgaY;
    logic [2:0]  vgaColour;
    logic        plot;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sprite_plotter dut (
        .clk                (clk),
        .spritePlotterReset (rst),
        .start              (start),
        .originX            (originX),
        .originY            (originY),
        .spriteAddress      (spriteAddress),
        .romColour          (romColour),
        .vgaX               (vgaX),
        .vgaY               (vgaY),
        .vgaColour          (vgaColour),
        .plot               (plot),
        .busy               (busy),
        .done               (done)
    );

    logic [2:0] rom [0:2047];

    // Synchronous sprite ROM: data valid the cycle after the address.
    always @(posedge clk) romColour <= rom[spriteAddress];

    int n_cmp = 0;
    int n_err = 0;
    int cur_n = 0;
    int last_cnt = 0;
    int exp_cnt;
    bit exp_plot [0:NCYC];
    int exp_x    [0:NCYC];
    int exp_y    [0:NCYC];
    int exp_c    [0:NCYC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle T+%0d: got %0d expected %0d", tag, cur_n, got, exp);
        end
    endtask

    // Expected plot stream: pixel k of the raster appears at cycle T+2+k.
    task automatic build_model(input int ox, input int oy);
        exp_cnt = 0;
        for (int n = 0; n <= NCYC; n++) exp_plot[n] = 1'b0;
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                int k = r * SW + c;
                int x = ox + c;
                int y = oy + r;
                if (x < 160 && y < 120 && (!TRANSP || rom[k] != 3'd0)) begin
                    exp_plot[k + 2] = 1'b1;
                    exp_x[k + 2]    = x;
                    exp_y[k + 2]    = y;
                    exp_c[k + 2]    = int'(rom[k]);
                    exp_cnt++;
                end
            end
        end
    endtask

    // Called at a negedge with the DUT idle; start is sampled at the next posedge (edge T).
    task automatic run_draw(input int ox, input int oy, input bit hold,
                            input int inject_at, input int reset_at);
        int cnt = 0;
        int exp_addr;
        build_model(ox, oy);
        start   = 1'b1;
        originX = 8'(ox);
        originY = 7'(oy);
        for (int n = 1; n <= NCYC; n++) begin
            @(negedge clk);
            cur_n = n;
            if (n == 1 && !hold) start = 1'b0;
            exp_addr = (n <= 1600) ? n - 1 : ((n <= 1602) ? 1599 : 0);
            check("busy", 32'(busy), 32'(n <= 1601));
            check("done", 32'(done), 32'(n == 1602));
            check("plot", 32'(plot), 32'(exp_plot[n]));
            check("addr", 32'(spriteAddress), 32'(exp_addr));
            if (plot) cnt++;
            if (exp_plot[n]) begin
                check("vgaX", 32'(vgaX), 32'(exp_x[n]));
                check("vgaY", 32'(vgaY), 32'(exp_y[n]));
                check("colour", 32'(vgaColour), 32'(exp_c[n]));
            end
            if (n == inject_at) begin
                start   = 1'b1;
                originX = 8'd0;
                originY = 7'd0;
            end
            if (n == inject_at + 1) begin
                start   = 1'b0;
                originX = 8'(ox);
                originY = 7'(oy);
            end
            if (n == reset_at) begin
                rst = 1'b1;
                #1;
                check("rst_plot", 32'(plot), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_addr", 32'(spriteAddress), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                last_cnt = -1;
                return;
            end
        end
        last_cnt = cnt;
        check("plot_count", 32'(cnt), 32'(exp_cnt));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 3'd0;
        rst     = 1'b1;
        start   = 1'b0;
        originX = 8'd0;
        originY = 7'd0;
        repeat (3) @(negedge clk);
        cur_n = 0;
        check("reset_plot", 32'(plot), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_addr", 32'(spriteAddress), 32'd0);
        check("reset_vgaX", 32'(vgaX), 32'd0);
        check("reset_vgaY", 32'(vgaY), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full on-screen sprite, ROM holds address[2:0].
        for (int i = 0; i < 2048; i++) rom[i] = 3'(i);
        run_draw(10, 20, 1'b0, -10, -10);
        if (!TRANSP) check("full_count", 32'(last_cnt), 32'd1600);

        // Bottom-right clipping with non-zero colours.
        for (int i = 0; i < 2048; i++) rom[i] = 3'($urandom_range(1, 7));
        run_draw(140, 100, 1'b0, -10, -10);
        check("clip_count", 32'(last_cnt), 32'd400);

        // Start pulsed mid-draw must be ignored.
        for (int i = 0; i < 2048; i++) rom[i] = 3'($urandom_range(0, 7));
        run_draw(60, 30, 1'b0, 500, -10);

        // Reset in the middle of a draw, then a full redraw.
        run_draw(20, 20, 1'b0, -10, 800);
        run_draw(0, 0, 1'b0, -10, -10);

        // Back-to-back with start held high.
        run_draw(30, 40, 1'b1, -10, -10);
        run_draw(5, 7, 1'b0, -10, -10);

        // Random origins, including off-screen ones.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 2048; i++) rom[i] = 3'($urandom_range(0, 7));
            run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1'b0, -10, -10);
        end

        // Single visible pixel when all but address 0 is transparent.
        for (int i = 0; i < 2048; i++) rom[i] = 3'd0;
        rom[0] = 3'd5;
        run_draw(3, 4, 1'b0, -10, -10);
`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
        check("transp_count", 32'(last_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
Writer-side counterpart to the screen/sprite address counters. On a start pulse it scans one 40x40 sprite ROM in raster order and drives the VGA adapter write port (x, y, colour, plot) so the sprite is drawn at a latched screen origin. It sits between the game FSM (start/done) and the 160x120 VGA framebuffer adapter, with the sprite ROM on its read side.

Parameters:
SPRITE_W, 40, sprite width in pixels
SPRITE_H, 40, sprite height in pixels
SCREEN_W, 160, framebuffer width; x >= SCREEN_W is clipped
SCREEN_H, 120, framebuffer height; y >= SCREEN_H is clipped
COLOUR_W, 3, colour bits per pixel

Ports:
clk  in  1  system clock (50 MHz)
spritePlotterReset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
originX  in  8  sprite top-left x; latched on accepted start
originY  in  7  sprite top-left y; latched on accepted start
spriteAddress  out  11  sprite ROM read address (row*SPRITE_W + col)
romColour  in  COLOUR_W  ROM data; valid the cycle after spriteAddress
vgaX  out  8  framebuffer write x
vgaY  out  7  framebuffer write y
vgaColour  out  COLOUR_W  framebuffer write colour (= romColour)
plot  out  1  framebuffer write enable
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): state IDLE; spriteAddress=0, vgaX=0, vgaY=0, plot=0, busy=0, done=0; col/row counters and latched origin = 0.
- States: IDLE -> DRAW (start=1) -> FLUSH (col=SPRITE_W-1 and row=SPRITE_H-1) -> DONE -> IDLE (unconditional).
- Start accepted at edge T: originX/originY latched; at T+1 state=DRAW, busy=1, spriteAddress=0, col=row=0.
- DRAW: each cycle col increments; at col=SPRITE_W-1 col wraps to 0 and row increments. spriteAddress = registered linear count 0..1599, +1 per cycle, no gaps.
- Pipeline: pixel-stage registers (valid, x=originX+col, y=originY+row) delayed one cycle to align with ROM latency; plot/vgaX/vgaY from this stage, vgaColour=romColour combinational.
- Address k issued at T+1+k; its plot at T+2+k. First plot T+2 (x=originX, y=originY); last plot T+1601 (x=originX+39, y=originY+39).
- FLUSH: no new address; last pixel drains. DONE at T+1602: done=1, busy=0, plot=0. Start accepted again from T+1603.
- Arithmetic: x sum computed 9 bits, y sum 8 bits; plot=0 if x >= SCREEN_W or y >= SCREEN_H (clipped pixel still consumes its cycle and address; no wrap onto screen).
- start while busy/FLUSH/DONE: ignored, origin not re-latched.
- plot is 0 outside DRAW-aligned pixel stage; vgaX/vgaY hold last value when plot=0.
- spriteAddress holds 1599 through FLUSH/DONE, returns to 0 in IDLE.

Optional Feature:
SPRITE_PLOTTER_TRANSPARENCY_EN: when defined, a parameter TRANSPARENT_COLOUR (default 0) is added and plot is additionally gated off when romColour == TRANSPARENT_COLOUR; timing, addresses and done unchanged. When undefined, every on-screen pixel is plotted regardless of colour.

Decomposition:
- Shared package: screen/sprite dimension constants, coordinate widths (X_W=8, Y_W=7, SPRITE_ADDR_W=11), state enum {IDLE, DRAW, FLUSH, DONE}.
- One sub-module: sprite_pixel_scanner — col/row counters with wrap, linear address, last-pixel flag; enabled by DRAW, cleared by reset/start.

Test Plan:
- Reset, start with origin (10,20), ROM = address[2:0] -> exactly 1600 plots, first at T+2 (10,20,colour 0), last at T+1601 (49,59), done one cycle at T+1602, busy high T+1..T+1601.
- Origin (140,100) -> only pixels x<=159,y<=119 plotted (20x20=400 plots); done still at T+1602.
- start pulsed at T+500 during draw with origin (0,0) -> ignored; plot coordinates continue from first origin; one done only.
- Assert spritePlotterReset at T+800 -> same cycle plot=0, busy=0, spriteAddress=0; next start draws a full sprite from address 0.
- Back-to-back: start held high continuously -> second draw accepted at T+1603, no overlap of plot streams.
- With SPRITE_PLOTTER_TRANSPARENCY_EN, ROM all zeros except address 0 = 5 -> single plot at T+2 colour 5; done timing unchanged.
